// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
// Turns the slow divided clock into a one-clk-wide CPU advance pulse.
// In free-run mode every rising edge of the divided clock (a "tick") yields
// one pulse. In single-step mode a debounced button press arms the block and
// the next tick yields exactly one pulse. A halt request parks the block in
// HALTED until reset. Everything runs on the fast board clock.
//
// Ports:
//   clk        board clock, sole clock domain
//   reset      synchronous, active-high reset
//   clk_div    divided clock level, sampled as data
//   run_mode   1 = free-run, 0 = single-step (synchronous level)
//   step_btn   raw asynchronous bouncing push-button, active high
//   halt       CPU halt request (synchronous level)
//   cpu_en     registered one-cycle CPU advance pulse
//   running    high while in RUN
//   halted     high while in HALTED
//   step_count number of cpu_en pulses issued (only with CPU_STEP_COUNT_EN)
//
// Optional feature macro: CPU_STEP_COUNT_EN adds the step_count port and its
// 32-bit wrapping counter.

module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_CNT_W        = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_div,
  input  logic        run_mode,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic        running,
  output logic        halted
`ifdef CPU_STEP_COUNT_EN
  ,
  output logic [31:0] step_count
`endif
);

  typedef enum logic [1:0] {
    StStopped = 2'd0,
    StRun     = 2'd1,
    StHalted  = 2'd2
  } state_t;

  localparam logic [DB_CNT_W-1:0] DbLast = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                div_q;
  logic [1:0]          sync_q;
  logic                dbLevel_q, dbLevel_d;
  logic                dbPrev_q;
  logic [DB_CNT_W-1:0] dbCnt_q, dbCnt_d;
  logic                pending_q, pending_d;
  state_t              state_q, state_d;
  logic                cpuEn_q, cpuEn_d;
  logic                running_q, halted_q;
  logic                tick, press, syncOut;

  assign tick    = clk_div & ~div_q;
  assign syncOut = sync_q[1];
  assign press   = dbLevel_q & ~dbPrev_q;

  // Debounce: the synchronized level must disagree with the accepted level
  // for DEBOUNCE_CYCLES consecutive cycles before it is accepted; any cycle
  // of agreement restarts the count from zero.
  always_comb begin
    dbLevel_d = dbLevel_q;
    dbCnt_d   = '0;
    if (syncOut != dbLevel_q) begin
      if (dbCnt_q == DbLast) begin
        dbLevel_d = ~dbLevel_q;
      end else begin
        dbCnt_d = dbCnt_q + DB_CNT_W'(1);
      end
    end
  end

  // Next-state logic. Priority is halt, then a run_mode change, then
  // tick/press, so a tick coinciding with halt or a mode change is swallowed.
  // A press that arrives while a step is already armed is dropped.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cpuEn_d   = 1'b0;
    case (state_q)
      StStopped: begin
        if (halt) begin
          state_d   = StHalted;
          pending_d = 1'b0;
        end else if (run_mode) begin
          state_d   = StRun;
          pending_d = 1'b0;
        end else if (tick && pending_q) begin
          cpuEn_d   = 1'b1;
          pending_d = 1'b0;
        end else if (press) begin
          pending_d = 1'b1;
        end
      end
      StRun: begin
        if (halt) begin
          state_d   = StHalted;
          pending_d = 1'b0;
        end else if (!run_mode) begin
          state_d   = StStopped;
          pending_d = 1'b0;
        end else if (tick) begin
          cpuEn_d = 1'b1;
        end
      end
      StHalted: begin
        state_d   = StHalted;
        pending_d = 1'b0;
      end
      default: begin
        state_d   = StStopped;
        pending_d = 1'b0;
      end
    endcase
  end

  // State, button path and registered outputs. The status outputs are loaded
  // from the next state so they always agree with the current state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= 1'b0;
      sync_q    <= 2'b00;
      dbLevel_q <= 1'b0;
      dbPrev_q  <= 1'b0;
      dbCnt_q   <= '0;
      pending_q <= 1'b0;
      state_q   <= StStopped;
      cpuEn_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      div_q     <= clk_div;
      sync_q    <= {sync_q[0], step_btn};
      dbLevel_q <= dbLevel_d;
      dbPrev_q  <= dbLevel_q;
      dbCnt_q   <= dbCnt_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      cpuEn_q   <= cpuEn_d;
      running_q <= (state_d == StRun);
      halted_q  <= (state_d == StHalted);
    end
  end

  assign cpu_en  = cpuEn_q;
  assign running = running_q;
  assign halted  = halted_q;

`ifdef CPU_STEP_COUNT_EN
  logic [31:0] stepCount_q;

  // Counts issued pulses; wraps naturally at 32 bits and holds in HALTED
  // because no pulses are issued there.
  always_ff @(posedge clk) begin
    if (reset) begin
      stepCount_q <= '0;
    end else if (cpuEn_q) begin
      stepCount_q <= stepCount_q + 32'd1;
    end
  end

  assign step_count = stepCount_q;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl
// Self-checking bench for cpu_step_ctrl. Inputs change 2 time units after
// each rising clk edge; a single compare process on the falling edge checks
// the DUT against a behavioural model and then advances the model with the
// inputs the DUT will sample on the next rising edge. Directed phases add
// literal expectations (pulse counts, status bits) that pin the model.

module tb_cpu_step_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset, clk_div, run_mode, step_btn, halt;
  logic cpu_en, running, halted;
`ifdef CPU_STEP_COUNT_EN
  logic [31:0] step_count;
`endif

  logic [3:0] divCnt;
  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  int cycleNum = 0;
  int lastPulse = -1;
  int lastGap = 0;

  // Model state: plain booleans and a sample history, no state encoding.
  bit          mValid = 0;
  bit          mRun, mHalt, mPend, mCpuEn, mPrevDiv;
  bit          mDb, mDbOld, mPipe0, mPipe1;
  bit          mWin[$];
  logic [31:0] mCount;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DB_CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_div(clk_div),
    .run_mode(run_mode),
    .step_btn(step_btn),
    .halt(halt),
    .cpu_en(cpu_en),
    .running(running),
    .halted(halted)
`ifdef CPU_STEP_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, actual, expected, cycleNum);
    end
  endtask

  // One clk cycle of inputs; the divider pattern gives a tick whenever the
  // new divCnt value is 8.
  task automatic applyStimulus(input logic r, input logic rm, input logic b,
                               input logic h);
    @(posedge clk);
    #2;
    reset    = r;
    run_mode = rm;
    step_btn = b;
    halt     = h;
    divCnt   = divCnt + 4'd1;
    clk_div  = divCnt[3];
  endtask

  // Idle until the next applyStimulus call would set divCnt to target.
  task automatic advanceTo(input logic [3:0] target, input logic rm);
    for (int i = 0; i < 16 && (divCnt + 4'd1) != target; i++)
      applyStimulus(1'b0, rm, 1'b0, 1'b0);
  endtask

  // Behavioural model of one clk cycle using the inputs currently applied.
  // The button is seen two cycles late; the accepted level flips once the
  // last DB seen samples all disagree with it; a press is the cycle where
  // the accepted level has just become 1.
  task automatic modelStep();
    bit tick, press, seen, allDiff, nextEn;
    if (reset) begin
      mValid = 1; mRun = 0; mHalt = 0; mPend = 0; mCpuEn = 0; mPrevDiv = 0;
      mDb = 0; mDbOld = 0; mPipe0 = 0; mPipe1 = 0; mCount = 0;
      mWin.delete();
      return;
    end
    if (!mValid) return;
    tick     = clk_div && !mPrevDiv;
    mPrevDiv = clk_div;
    press    = mDb && !mDbOld;
    seen     = mPipe1;
    mPipe1   = mPipe0;
    mPipe0   = step_btn;
    mWin.push_back(seen);
    if (mWin.size() > DB) void'(mWin.pop_front());
    allDiff = (mWin.size() == DB);
    foreach (mWin[i]) if (mWin[i] == mDb) allDiff = 0;
    mDbOld = mDb;
    if (allDiff) mDb = !mDb;
    if (mCpuEn) mCount = mCount + 32'd1;
    nextEn = 0;
    if (mHalt) begin
      nextEn = 0;
    end else if (halt) begin
      mHalt = 1; mRun = 0; mPend = 0;
    end else if (mRun) begin
      if (!run_mode) begin mRun = 0; mPend = 0; end
      else if (tick) nextEn = 1;
    end else begin
      if (run_mode) begin mRun = 1; mPend = 0; end
      else if (tick && mPend) begin nextEn = 1; mPend = 0; end
      else if (press) mPend = 1;
    end
    mCpuEn = nextEn;
  endtask

  // Compare process: check, record pulses, then advance the model.
  always @(negedge clk) begin
    cycleNum++;
    if (mValid) begin
      checkOutput("cpu_en", {31'd0, cpu_en}, {31'd0, mCpuEn});
      checkOutput("running", {31'd0, running}, {31'd0, mRun});
      checkOutput("halted", {31'd0, halted}, {31'd0, mHalt});
`ifdef CPU_STEP_COUNT_EN
      checkOutput("step_count", step_count, mCount);
`endif
    end
    if (cpu_en === 1'b1) begin
      pulseCount++;
      if (lastPulse >= 0) lastGap = cycleNum - lastPulse;
      lastPulse = cycleNum;
    end
    modelStep();
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int p0;
    logic rm, b, h, r;
    reset = 1'b1; run_mode = 1'b0; step_btn = 1'b0; halt = 1'b0;
    clk_div = 1'b0; divCnt = 4'd0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    checkOutput("reset_running", {31'd0, running}, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);

    // Free-run: running one cycle after run_mode, 6 pulses per 96 cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("freerun_running", {31'd0, running}, 32'd1);
    p0 = pulseCount;
    repeat (96) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("freerun_pulses", pulseCount - p0, 32'd6);
    checkOutput("freerun_period", lastGap, 32'd16);

    // Mode switch on a tick cycle: no pulse, running drops next cycle
    advanceTo(4'd8, 1'b1);
    p0 = pulseCount;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("modeswitch_running", {31'd0, running}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("modeswitch_pulses", pulseCount - p0, 32'd0);

    // Single-step with bounce: exactly one pulse over several ticks
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    p0 = pulseCount;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("step_bounce_pulses", pulseCount - p0, 32'd1);

    // Dropped press: presses debounce at offsets 6 and 16 between ticks at
    // offsets 2 and 18, so the second press finds a step already armed.
    advanceTo(4'd6, 1'b0);
    p0 = pulseCount;
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dropped_press_pulses", pulseCount - p0, 32'd1);

    // Halt on a tick cycle in RUN, then ignore everything until reset
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    advanceTo(4'd8, 1'b1);
    p0 = pulseCount;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_running", {31'd0, running}, 32'd0);
    rm = 1'b1; b = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i % 5 == 0) rm = ~rm;
      b = ($urandom_range(0, 3) == 0) ? ~b : b;
      applyStimulus(1'b0, rm, b, 1'($urandom_range(0, 1)));
    end
    checkOutput("halt_pulses", pulseCount - p0, 32'd0);
    checkOutput("halt_stays", {31'd0, halted}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_reset_halted", {31'd0, halted}, 32'd0);
    checkOutput("halt_reset_running", {31'd0, running}, 32'd0);

`ifdef CPU_STEP_COUNT_EN
    // Counter wrap from a preloaded value, then reset mid-run
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    force dut.stepCount_q = 32'hFFFF_FFFE;
    mCount = 32'hFFFF_FFFE;
    #1;
    release dut.stepCount_q;
    p0 = pulseCount;
    for (int i = 0; i < 80 && (pulseCount - p0) < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("count_pulses", pulseCount - p0, 32'd3);
    checkOutput("count_wrapped", step_count, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("count_reset", step_count, 32'h0);
`endif

    // Randomized traffic checked cycle by cycle against the model
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    rm = 1'b0; b = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rm = ($urandom_range(0, 39) == 0) ? ~rm : rm;
      b  = ($urandom_range(0, 5) == 0) ? ~b : b;
      h  = ($urandom_range(0, 399) == 0);
      r  = ($urandom_range(0, 249) == 0);
      applyStimulus(r, rm, b, h);
    end
    applyStimulus(1'b0, rm, b, 1'b0);
    applyStimulus(1'b0, rm, b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Consumes the slow divided clock from the clock divider and generates a one-`clk`-wide CPU clock-enable pulse, `cpu_en`.
- Modes: free-run (one pulse per divided-clock rising edge) or single-step (one pulse per debounced button press, aligned to the next divided-clock edge).
- Stops permanently on a CPU halt request (e.g. syscall exit) until reset.
- Sits between the clock divider and the single-cycle CPU/board I/O. All logic runs on the fast board clock.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive `clk` cycles a synchronized button level must stay stable before it is accepted (board build overrides to 1_000_000).
- DB_CNT_W, 20, width of the debounce counter; must satisfy 2^DB_CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  board clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- clk_div  in  1  divided clock level from the divider; sampled as data on `clk`.
- run_mode  in  1  1 = free-run, 0 = single-step; level, already synchronous to `clk`.
- step_btn  in  1  raw, asynchronous, bouncing push-button; active high.
- halt  in  1  CPU halt request; level, synchronous to `clk`.
- cpu_en  out  1  one-cycle CPU advance pulse.
- running  out  1  high while in RUN state.
- halted  out  1  high while in HALTED state.
- step_count  out  32  number of `cpu_en` pulses issued; present only with the optional feature.

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high: all registers are cleared on the first `clk` rising edge where `reset`=1.
- Reset values:
  - `cpu_en`=0, `running`=0, `halted`=0, `step_count`=0.
  - state=STOPPED; internal: sync flops=0, debounced level=0, debounce counter=0, `div_q`=0, pending=0.
- Tick detection:
  - `div_q` <= `clk_div` every cycle.
  - tick = `clk_div` & ~`div_q`, combinational, one cycle per divided-clock rising edge.
- Button path:
  - 2-flop synchronizer, then debounce.
  - While the sync output equals the debounced level: counter is held at 0.
  - Otherwise: counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - press = rising edge of the debounced level (one-cycle event).
- States:
  - STOPPED (single-step idle/armed)
    - `run_mode`=1 -> RUN.
    - press -> set pending.
    - tick while pending=1 -> assert `cpu_en` next cycle, clear pending.
    - Presses while pending=1 are dropped, not queued.
  - RUN
    - tick -> `cpu_en`=1 next cycle (latency 1 `clk` from the tick cycle).
    - `run_mode`=0 -> STOPPED, pending cleared; no `cpu_en` for a tick in that same cycle.
    - Presses are ignored.
  - HALTED
    - `cpu_en` held 0; ticks, presses and `run_mode` are ignored.
    - Exit only via `reset`.
- Transition priority (highest first): `reset`, `halt` (from STOPPED or RUN -> HALTED), `run_mode` change, tick/press. A tick in the same cycle as `halt` produces no `cpu_en`.
- `cpu_en` is registered. It is never high on two consecutive cycles, and never high during or after the cycle following entry to HALTED.
- `running` = (state==RUN), `halted` = (state==HALTED). Both are registered: they reflect the state the cycle after the transition.
- Reset mid-pulse: `cpu_en` drops at the reset edge; pending and any partial debounce are discarded.

Optional Feature:
- Macro: CPU_STEP_COUNT_EN.
- Defined: `step_count` port exists. It increments by 1 on every cycle where `cpu_en`=1 and wraps from 0xFFFF_FFFF to 0. It is cleared by `reset` and holds its value in HALTED.
- Not defined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4; `clk_div` toggles every 8 `clk` cycles, giving a tick every 16 cycles.
- Free-run: `reset`, then `run_mode`=1 for 100 cycles -> `running`=1 one cycle after; `cpu_en` pulses 1 cycle after each tick, period 16, width 1; 6 pulses seen.
- Single-step with bounce: `run_mode`=0; `step_btn` toggles 1/0/1 at 1-cycle spacing, then holds 1 for 10 cycles -> exactly one `cpu_en`, at the first tick after the debounced rise; no pulse on later ticks.
- Dropped press: two clean presses (each held 6 cycles) inside one 16-cycle tick window -> only one `cpu_en`.
- Halt priority: in RUN, assert `halt` on a tick cycle -> no `cpu_en`; `halted`=1 next cycle; 64 further cycles with presses and `run_mode` toggles -> `cpu_en` stays 0; `reset` -> `halted`=0, state STOPPED.
- Mode switch on tick: `run_mode` 1->0 in a tick cycle -> no `cpu_en`, `running`=0 next cycle.
- With CPU_STEP_COUNT_EN defined: preload via forcing `step_count`=0xFFFF_FFFE, run 3 ticks -> values 0xFFFF_FFFF, 0x0, 0x1; `reset` mid-run -> 0.
